// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: shared FSM state encoding and default timing constants for step_ctrl.
package step_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_STEP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;
  localparam int DB_CYCLES_DEF     = 500000;
  localparam int RUN_DIV_DEF       = 100000000;
  localparam int CNT_W_DEF         = 27;
  localparam int REPEAT_DELAY_DEF  = 50000000;
  localparam int REPEAT_PERIOD_DEF = 10000000;
endpackage

// File: rtl/pb_filter.sv
// pb_filter: 2-flop synchronizer plus debounce counter for a raw pushbutton.
// Ports: clk, rst (async active-low), pb (raw, async) -> pb_level (debounced),
//        press (one-cycle pulse on each debounced 0->1 transition).
module pb_filter
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic pb_level,
  output logic press
);
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             prev_q, prev_d;
  // The counter only advances while the synchronized input disagrees with the
  // debounced level, so any bounce back to agreement restarts the count.
  always_comb begin
    sync_d  = {sync_q[0], pb};
    prev_d  = level_q;
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) level_d = sync_q[1];
      else cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end
  assign pb_level = level_q;
  assign press    = level_q & ~prev_q;
endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: turns a debounced pushbutton and run/step switch into a one-cycle processor step enable.
// Ports: clk, rst (async active-low), pb (raw button), run_mode (1 = auto-run)
//        -> step_en (one-cycle advance), pb_level (debounced button),
//           step_count (wrapping count of step_en pulses), state_o (STEP/RUN/PAUSED).
// Optional: define STEP_REPEAT_EN to auto-repeat steps while the button is held in STEP.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int RUN_DIV   = RUN_DIV_DEF,
  parameter int CNT_W     = CNT_W_DEF
`ifdef STEP_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pb,
  input  logic        run_mode,
  output logic        step_en,
  output logic        pb_level,
  output logic [15:0] step_count,
  output logic [1:0]  state_o
);
  logic             press;
  logic [1:0]       run_q, run_d;
  logic             sync_run;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             step_q, step_d;
  logic [15:0]      count_q, count_d;
  logic             rep_fire;

  pb_filter #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_pb (
    .clk      (clk),
    .rst      (rst),
    .pb       (pb),
    .pb_level (pb_level),
    .press    (press)
  );

  assign run_d    = {run_q[0], run_mode};
  assign sync_run = run_q[1];

`ifdef STEP_REPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             rep_arm_q, rep_arm_d;
  logic             rep_active;
  // Counts while the button stays held in STEP; first waits the long delay,
  // then switches to the shorter period once armed.
  always_comb begin
    rep_active = (state_q == ST_STEP) && !sync_run && pb_level && !press;
    rep_fire   = rep_active &&
                 (rep_q == (rep_arm_q ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1)));
    rep_d      = (rep_active && !rep_fire) ? rep_q + CNT_W'(1) : '0;
    rep_arm_d  = rep_active && (rep_arm_q || rep_fire);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q     <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_q     <= rep_d;
      rep_arm_q <= rep_arm_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // A mode change is checked first in every state so it always beats a press;
  // a press in RUN is checked before the divider terminal count.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    step_d  = 1'b0;
    count_d = count_q + {15'd0, step_q};
    case (state_q)
      ST_STEP: begin
        if (sync_run) state_d = ST_RUN;
        else step_d = press | rep_fire;
      end
      ST_RUN: begin
        if (!sync_run) state_d = ST_STEP;
        else if (press) state_d = ST_PAUSED;
        else if (div_q == CNT_W'(RUN_DIV - 1)) step_d = 1'b1;
        else div_d = div_q + CNT_W'(1);
      end
      ST_PAUSED: begin
        if (!sync_run) state_d = ST_STEP;
        else if (press) state_d = ST_RUN;
      end
      default: state_d = ST_STEP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q   <= '0;
      state_q <= ST_STEP;
      div_q   <= '0;
      step_q  <= 1'b0;
      count_q <= '0;
    end else begin
      run_q   <= run_d;
      state_q <= state_d;
      div_q   <= div_d;
      step_q  <= step_d;
      count_q <= count_d;
    end
  end

  assign step_en    = step_q;
  assign step_count = count_q;
  assign state_o    = state_q;
endmodule
